// File: rtl/gptp_2.sv
// gptp_2 -- gPTP slave time engine with TX frame timestamp insertion.
//
// Purpose:
//   RX side: takes Sync and Follow_Up frames from an RX buffer. It latches
//   the Sync ingress time t2 and the Follow_Up master time t1, then computes
//   offset = t1 + LINK_DELAY_NS - t2 and syntonised time = t1 + LINK_DELAY_NS.
//   The result is offered to the RTC through a valid/ready hold.
//   TX side: copies a FRAME_WORDS-word template from the TX template buffer to
//   the TX buffer. Word TS_WORD is replaced by the current RTC sample.
//   Timestamps are {epoch[15:0], sec[31:0], ns[31:0]}, with ns in 0..999_999_999.
//
// Optional feature (macro GPTP_RATE_ADJ_EN):
//   After each calculation, rtc_increment moves one LSB toward matching the
//   local interval to the master interval. It stays within INC_NOMINAL +/- 2^12.
//   Without the macro, rtc_increment is fixed at INC_NOMINAL.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   gptp_vaild / rtc_ready        RTC update handshake
//   gptp_sw                       set after the first completed calculation
//   syntonised_*_field_r          corrected time (t1 + link delay)
//   nanosec/sec/epoch_offset      t1 + link delay - t2
//   rtc_increment                 RTC step, 16 fractional ns bits
//   rtc_*_field                   live RTC sample
//   rx_gptp_rd_*                  RX buffer read port (vaild[7]=1 means no frame)
//   gptp_wr_vaild_ready           TX buffer free
//   gptp_rd_addr / gptp_rd_data   TX template read port (1-cycle latency)
//   gptp_wr_*                     TX buffer write port
//   gptp_wr_ready                 frame-sent pulse
module gptp_2 #(
    parameter int          FRAME_WORDS   = 16,
    parameter int          TS_WORD       = 2,
    parameter int          LINK_DELAY_NS = 0,
    parameter logic [25:0] INC_NOMINAL   = 26'h80000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        gptp_vaild,
    input  logic        rtc_ready,
    output logic        gptp_sw,
    output logic [31:0] syntonised_nanosec_field_r,
    output logic [31:0] syntonised_sec_field_r,
    output logic [15:0] syntonised_epoch_field_r,
    output logic [29:0] nanosec_offset,
    output logic [31:0] sec_offset,
    output logic [15:0] epoch_offset,
    output logic [25:0] rtc_increment,
    input  logic [31:0] rtc_nanosec_field,
    input  logic [31:0] rtc_sec_field,
    input  logic [15:0] rtc_epoch_field,
    input  logic [7:0]  rx_gptp_rd_vaild,
    input  logic [79:0] rx_gptp_rd_data,
    output logic [7:0]  rx_gptp_rd_addr,
    output logic        rx_gptp_rd_ready,
    input  logic        gptp_wr_vaild_ready,
    input  logic [79:0] gptp_rd_data,
    output logic [7:0]  gptp_rd_addr,
    output logic [7:0]  gptp_wr_addr,
    output logic [79:0] gptp_wr_data,
    output logic        gptp_wr_vaild,
    input  logic        gptp_wr_ready
);

    typedef enum logic [2:0] {IDLE, RX_RD, RX_CALC, TX_RD, TX_WAIT} state_t;

    localparam logic [32:0] NS_PER_SEC = 33'd1_000_000_000;
    localparam logic [31:0] LINK_D     = 32'(LINK_DELAY_NS);
    localparam logic [8:0]  LAST_IDX   = 9'(FRAME_WORDS - 1);
    localparam logic [7:0]  TS_IDX     = 8'(TS_WORD);
    localparam logic [3:0]  MT_SYNC    = 4'h0;
    localparam logic [3:0]  MT_FUP     = 4'h8;

    // Adds a sub-second delay to a timestamp. A carry from ns goes into sec,
    // and a carry from sec goes into epoch.
    function automatic logic [79:0] ts_add_ns(input logic [79:0] t, input logic [31:0] d);
        logic [32:0] ns;
        logic [32:0] sec;
        logic [15:0] ep;
        ns  = {1'b0, t[31:0]} + {1'b0, d};
        sec = {1'b0, t[63:32]};
        if (ns >= NS_PER_SEC) begin
            ns  = ns - NS_PER_SEC;
            sec = sec + 33'd1;
        end
        ep = t[79:64] + {15'd0, sec[32]};
        return {ep, sec[31:0], ns[31:0]};
    endfunction

    // Computes a - b on timestamps. A negative ns result borrows one second.
    // A sec borrow comes out of the epoch field, which wraps mod 2^16.
    function automatic logic [79:0] ts_sub(input logic [79:0] a, input logic [79:0] b);
        logic [32:0] ns;
        logic [32:0] sec;
        logic [15:0] ep;
        if (a[31:0] >= b[31:0]) begin
            ns  = {1'b0, a[31:0]} - {1'b0, b[31:0]};
            sec = {1'b0, a[63:32]} - {1'b0, b[63:32]};
        end else begin
            ns  = {1'b0, a[31:0]} + NS_PER_SEC - {1'b0, b[31:0]};
            sec = {1'b0, a[63:32]} - {1'b0, b[63:32]} - 33'd1;
        end
        ep = a[79:64] - b[79:64] - {15'd0, sec[32]};
        return {ep, sec[31:0], ns[31:0]};
    endfunction

    state_t      state, state_nxt;
    logic        rx_present;
    logic        rx_phase;      // 0: address cycle, 1: data cycle of the RX read
    logic        rx_is_fup;     // latched type: 1 = Follow_Up, 0 = Sync
    logic        rx_keep;       // latched type is Sync or Follow_Up
    logic        have_sync;
    logic [79:0] t1, t2;
    logic [79:0] t1_adj, offset;
    logic [7:0]  tx_idx;
    logic        wr_vld;
    logic [7:0]  wr_addr_q;
    logic [2:0]  unused_vaild_bits;

    assign unused_vaild_bits = rx_gptp_rd_vaild[6:4];
    assign rx_present        = ~rx_gptp_rd_vaild[7];
    assign t1_adj            = ts_add_ns(t1, LINK_D);
    assign offset            = ts_sub(t1_adj, t2);

    always_comb begin
        state_nxt        = state;
        rx_gptp_rd_ready = 1'b0;
        gptp_rd_addr     = 8'd0;
        unique case (state)
            IDLE: begin
                if (rx_present)               state_nxt = RX_RD;
                else if (gptp_wr_vaild_ready) state_nxt = TX_RD;
            end
            RX_RD: begin
                rx_gptp_rd_ready = ~rx_phase;
                if (rx_phase)
                    state_nxt = (rx_keep && rx_is_fup && have_sync) ? RX_CALC : IDLE;
            end
            RX_CALC: state_nxt = IDLE;
            TX_RD: begin
                gptp_rd_addr = tx_idx;
                if ({1'b0, tx_idx} == LAST_IDX) state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                if (gptp_wr_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            rx_phase                   <= 1'b0;
            rx_is_fup                  <= 1'b0;
            rx_keep                    <= 1'b0;
            have_sync                  <= 1'b0;
            t1                         <= '0;
            t2                         <= '0;
            tx_idx                     <= 8'd0;
            wr_vld                     <= 1'b0;
            wr_addr_q                  <= 8'd0;
            gptp_vaild                 <= 1'b0;
            gptp_sw                    <= 1'b0;
            nanosec_offset             <= '0;
            sec_offset                 <= '0;
            epoch_offset               <= '0;
            syntonised_nanosec_field_r <= '0;
            syntonised_sec_field_r     <= '0;
            syntonised_epoch_field_r   <= '0;
        end else begin
            state  <= state_nxt;
            wr_vld <= 1'b0;
            if (gptp_vaild && rtc_ready) gptp_vaild <= 1'b0;
            case (state)
                IDLE: begin
                    rx_phase <= 1'b0;
                    tx_idx   <= 8'd0;
                    if (rx_present) begin
                        rx_is_fup <= (rx_gptp_rd_vaild[3:0] == MT_FUP);
                        rx_keep   <= (rx_gptp_rd_vaild[3:0] == MT_FUP) ||
                                     (rx_gptp_rd_vaild[3:0] == MT_SYNC);
                    end
                end
                RX_RD: begin
                    if (!rx_phase) begin
                        rx_phase <= 1'b1;
                    end else if (rx_keep) begin
                        if (!rx_is_fup) begin
                            t2        <= rx_gptp_rd_data;
                            have_sync <= 1'b1;
                        end else if (have_sync) begin
                            t1 <= rx_gptp_rd_data;
                        end
                    end
                end
                RX_CALC: begin
                    // Set after the rtc_ready clear so that a newer result wins.
                    gptp_vaild                 <= 1'b1;
                    gptp_sw                    <= 1'b1;
                    have_sync                  <= 1'b0;
                    nanosec_offset             <= offset[29:0];
                    sec_offset                 <= offset[63:32];
                    epoch_offset               <= offset[79:64];
                    syntonised_nanosec_field_r <= t1_adj[31:0];
                    syntonised_sec_field_r     <= t1_adj[63:32];
                    syntonised_epoch_field_r   <= t1_adj[79:64];
                end
                TX_RD: begin
                    wr_vld    <= 1'b1;
                    wr_addr_q <= tx_idx;
                    tx_idx    <= tx_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Template data arrives the cycle after its address. The write therefore
    // forwards the read bus (or the live RTC sample) while wr_vld is high.
    assign gptp_wr_vaild   = wr_vld;
    assign gptp_wr_addr    = wr_addr_q;
    assign gptp_wr_data    = !wr_vld ? '0 :
                             (wr_addr_q == TS_IDX) ? {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field} :
                             gptp_rd_data;
    assign rx_gptp_rd_addr = 8'd0;

`ifdef GPTP_RATE_ADJ_EN
    localparam logic [25:0] INC_MIN = INC_NOMINAL - 26'd4096;
    localparam logic [25:0] INC_MAX = INC_NOMINAL + 26'd4096;

    logic [25:0] inc_q;
    logic [79:0] t1_prev, t2_prev, master_dt, local_dt;
    logic        have_prev;

    // Deltas are normalised with ns < 1e9, so a plain magnitude compare orders them.
    assign master_dt = ts_sub(t1, t1_prev);
    assign local_dt  = ts_sub(t2, t2_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q     <= INC_NOMINAL;
            t1_prev   <= '0;
            t2_prev   <= '0;
            have_prev <= 1'b0;
        end else if (state == RX_CALC) begin
            if (have_prev) begin
                if (local_dt > master_dt && inc_q > INC_MIN)      inc_q <= inc_q - 26'd1;
                else if (local_dt < master_dt && inc_q < INC_MAX) inc_q <= inc_q + 26'd1;
            end
            t1_prev   <= t1;
            t2_prev   <= t2;
            have_prev <= 1'b1;
        end
    end

    assign rtc_increment = inc_q;
`else
    assign rtc_increment = INC_NOMINAL;
`endif

endmodule

// File: tb/tb_gptp_2.sv
module tb_gptp_2;

    localparam int FW = 16;
    localparam int TS = 2;
    localparam int LINK_D = 0;
    localparam logic [127:0] NSEC = 128'd1000000000;
    localparam logic [127:0] MOD  = (128'd1 << 48) * NSEC;

    logic        clk = 1'b0;
    logic        reset;
    logic        gptp_vaild, rtc_ready, gptp_sw;
    logic [31:0] syntonised_nanosec_field_r, syntonised_sec_field_r;
    logic [15:0] syntonised_epoch_field_r;
    logic [29:0] nanosec_offset;
    logic [31:0] sec_offset;
    logic [15:0] epoch_offset;
    logic [25:0] rtc_increment;
    logic [31:0] rtc_nanosec_field, rtc_sec_field;
    logic [15:0] rtc_epoch_field;
    logic [7:0]  rx_gptp_rd_vaild;
    logic [79:0] rx_gptp_rd_data;
    logic [7:0]  rx_gptp_rd_addr;
    logic        rx_gptp_rd_ready;
    logic        gptp_wr_vaild_ready;
    logic [79:0] gptp_rd_data;
    logic [7:0]  gptp_rd_addr, gptp_wr_addr;
    logic [79:0] gptp_wr_data;
    logic        gptp_wr_vaild, gptp_wr_ready;

    int errors = 0;
    int checks = 0;
    logic [79:0] tmpl [FW];
    logic [7:0]  last_addr;

    always #5 clk = ~clk;

    gptp_2 #(.FRAME_WORDS(FW), .TS_WORD(TS), .LINK_DELAY_NS(LINK_D), .INC_NOMINAL(26'h80000)) dut (
        .clk(clk), .reset(reset),
        .gptp_vaild(gptp_vaild), .rtc_ready(rtc_ready), .gptp_sw(gptp_sw),
        .syntonised_nanosec_field_r(syntonised_nanosec_field_r),
        .syntonised_sec_field_r(syntonised_sec_field_r),
        .syntonised_epoch_field_r(syntonised_epoch_field_r),
        .nanosec_offset(nanosec_offset), .sec_offset(sec_offset), .epoch_offset(epoch_offset),
        .rtc_increment(rtc_increment),
        .rtc_nanosec_field(rtc_nanosec_field), .rtc_sec_field(rtc_sec_field),
        .rtc_epoch_field(rtc_epoch_field),
        .rx_gptp_rd_vaild(rx_gptp_rd_vaild), .rx_gptp_rd_data(rx_gptp_rd_data),
        .rx_gptp_rd_addr(rx_gptp_rd_addr), .rx_gptp_rd_ready(rx_gptp_rd_ready),
        .gptp_wr_vaild_ready(gptp_wr_vaild_ready), .gptp_rd_data(gptp_rd_data),
        .gptp_rd_addr(gptp_rd_addr), .gptp_wr_addr(gptp_wr_addr),
        .gptp_wr_data(gptp_wr_data), .gptp_wr_vaild(gptp_wr_vaild),
        .gptp_wr_ready(gptp_wr_ready)
    );

    // Reference model: a timestamp is a single count of nanoseconds.
    // The 48-bit seconds field wraps, so arithmetic is mod 2^48 seconds.
    function automatic logic [127:0] to_lin(input logic [79:0] t);
        logic [127:0] s;
        s = 128'(t[79:32]);
        return s * NSEC + 128'(t[31:0]);
    endfunction

    function automatic logic [79:0] from_lin(input logic [127:0] v);
        logic [127:0] s, n;
        n = v % NSEC;
        s = v / NSEC;
        return {s[47:0], n[31:0]};
    endfunction

    function automatic logic [79:0] rand_ts();
        return {16'($urandom), 32'($urandom), 32'($urandom_range(999_999_999))};
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [3:0] mtype, input logic [79:0] ts, input string tag,
                           input bit also_tx);
        bit seen = 1'b0;
        int first_c = -1;
        @(negedge clk);
        rx_gptp_rd_vaild = {4'h0, mtype};
        if (also_tx) gptp_wr_vaild_ready = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (rx_gptp_rd_ready) begin
                seen = 1'b1;
                first_c = c;
                chk({tag, "_addr"}, 80'(rx_gptp_rd_addr), 80'd0);
            end
        end
        chk({tag, "_rdy"}, 80'(seen), 80'd1);
        if (also_tx) chk({tag, "_rx_first"}, 80'(first_c), 80'd0);
        @(posedge clk);
        #1;
        rx_gptp_rd_data  = ts;
        rx_gptp_rd_vaild = 8'hff;
    endtask

    task automatic watch(input int n, output int strobes, output int vlds);
        strobes = 0;
        vlds = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (gptp_wr_vaild) strobes++;
            if (gptp_vaild) vlds++;
        end
    endtask

    task automatic run_frame(input string tag, input bit rand_rtc);
        int nwr = 0;
        logic [79:0] exp;
        last_addr = gptp_rd_addr;
        for (int c = 0; c < FW + 10; c++) begin
            @(posedge clk);
            #1;
            gptp_rd_data = tmpl[int'(last_addr) % FW];
            gptp_wr_vaild_ready = 1'b0;
            if (rand_rtc) begin
                rtc_nanosec_field = $urandom;
                rtc_sec_field     = $urandom;
                rtc_epoch_field   = 16'($urandom);
            end
            @(negedge clk);
            if (gptp_wr_vaild) begin
                exp = (nwr == TS) ? {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field}
                                  : tmpl[nwr % FW];
                chk($sformatf("%s_waddr%0d", tag, nwr), 80'(gptp_wr_addr), 80'(nwr));
                chk($sformatf("%s_wdata%0d", tag, nwr), gptp_wr_data, exp);
                nwr++;
            end
            last_addr = gptp_rd_addr;
        end
        chk({tag, "_count"}, 80'(nwr), 80'(FW));
    endtask

    initial begin
        int s, v;
        bit seen;
        logic [79:0] t1, t2;

        reset = 1'b1;
        rtc_ready = 1'b0;
        rtc_nanosec_field = '0;
        rtc_sec_field = '0;
        rtc_epoch_field = '0;
        rx_gptp_rd_vaild = 8'hff;
        rx_gptp_rd_data = '0;
        gptp_wr_vaild_ready = 1'b0;
        gptp_rd_data = '0;
        gptp_wr_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_vaild", 80'(gptp_vaild), 80'd0);
        chk("rst_sw", 80'(gptp_sw), 80'd0);
        chk("rst_inc", 80'(rtc_increment), 80'h80000);
        chk("rst_wr", {gptp_wr_data[76:0], gptp_wr_vaild, rx_gptp_rd_ready, gptp_wr_addr == 8'd0}, 80'd1);
        chk("rst_off", {epoch_offset, sec_offset, 2'b00, nanosec_offset}, 80'd0);
        chk("rst_synt", {syntonised_epoch_field_r, syntonised_sec_field_r, syntonised_nanosec_field_r}, 80'd0);
        reset = 1'b0;

        // TX frame with a constant template and a fixed RTC sample
        @(negedge clk);
        for (int i = 0; i < FW; i++) tmpl[i] = 80'habababaa;
        gptp_rd_data = 80'habababaa;
        rtc_epoch_field = 16'd0;
        rtc_sec_field = 32'd1;
        rtc_nanosec_field = 32'd5;
        gptp_wr_vaild_ready = 1'b1;
        run_frame("f1", 1'b0);

        // Stay in TX_WAIT until the sent pulse, even with the buffer free again
        gptp_wr_vaild_ready = 1'b1;
        watch(16, s, v);
        chk("wait_no_strobe", 80'(s), 80'd0);
        gptp_wr_vaild_ready = 1'b0;
        gptp_wr_ready = 1'b1;
        @(negedge clk);
        gptp_wr_ready = 1'b0;
        watch(5, s, v);
        chk("idle_no_strobe", 80'(s), 80'd0);

        // Second frame with a random template and an RTC that changes every cycle
        for (int i = 0; i < FW; i++) tmpl[i] = {16'($urandom), 32'($urandom), 32'($urandom)};
        gptp_wr_vaild_ready = 1'b1;
        run_frame("f2", 1'b1);
        gptp_wr_ready = 1'b1;
        @(negedge clk);
        gptp_wr_ready = 1'b0;

        // Directed Sync / Follow_Up
        send_rx(4'h0, {16'd0, 32'd1, 32'd5}, "sync0", 1'b0);
        send_rx(4'h8, {16'd0, 32'd2, 32'd3}, "fup0", 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (gptp_vaild) seen = 1'b1;
        end
        chk("calc0_vaild", 80'(seen), 80'd1);
        chk("calc0_ns", 80'(nanosec_offset), 80'd999_999_998);
        chk("calc0_sec", {epoch_offset, sec_offset}, 80'd0);
        chk("calc0_synt", {syntonised_epoch_field_r, syntonised_sec_field_r, syntonised_nanosec_field_r},
            {16'd0, 32'd2, 32'd3});
        chk("calc0_sw", 80'(gptp_sw), 80'd1);
        watch(5, s, v);
        chk("calc0_hold", 80'(v), 80'd5);
        rtc_ready = 1'b1;
        @(negedge clk);
        chk("calc0_release", 80'(gptp_vaild), 80'd0);
        rtc_ready = 1'b0;

        // Follow_Up with no preceding Sync
        send_rx(4'h8, rand_ts(), "fup_nosync", 1'b0);
        watch(8, s, v);
        chk("fup_nosync_vaild", 80'(v), 80'd0);

        // Random pairs; rtc_ready stays low, so each result overwrites the held one
        for (int i = 0; i < 6; i++) begin
            t2 = rand_ts();
            t1 = rand_ts();
            send_rx(4'h0, t2, $sformatf("rsync%0d", i), 1'b0);
            if (i % 2 == 1) send_rx(4'hb, rand_ts(), $sformatf("rign%0d", i), 1'b0);
            send_rx(4'h8, t1, $sformatf("rfup%0d", i), 1'b0);
            repeat (4) @(negedge clk);
            chk($sformatf("r%0d_off", i), {epoch_offset, sec_offset, 2'b00, nanosec_offset},
                from_lin((to_lin(t1) + 128'(LINK_D) + MOD - to_lin(t2)) % MOD));
            chk($sformatf("r%0d_synt", i),
                {syntonised_epoch_field_r, syntonised_sec_field_r, syntonised_nanosec_field_r},
                from_lin((to_lin(t1) + 128'(LINK_D)) % MOD));
            chk($sformatf("r%0d_vaild", i), 80'(gptp_vaild), 80'd1);
        end
        rtc_ready = 1'b1;
        @(negedge clk);
        rtc_ready = 1'b0;

        // RX wins over TX in IDLE; then reset in the middle of the TX copy
        send_rx(4'h0, rand_ts(), "prio", 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (gptp_wr_vaild) seen = 1'b1;
        end
        chk("prio_tx_started", 80'(seen), 80'd1);
        reset = 1'b1;
        #1;
        chk("midrst_wr", {gptp_wr_data[78:0], gptp_wr_vaild}, 80'd0);
        chk("midrst_ctl", {gptp_sw, gptp_vaild, rtc_increment}, 80'h80000);
        chk("midrst_off", {epoch_offset, sec_offset, 2'b00, nanosec_offset}, 80'd0);
        gptp_wr_vaild_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // The Sync latched before the reset has been forgotten
        send_rx(4'h8, rand_ts(), "fup_after_rst", 1'b0);
        watch(8, s, v);
        chk("fup_after_rst_vaild", 80'(v), 80'd0);
        chk("fup_after_rst_sw", 80'(gptp_sw), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gptp_2.md
GPTP_2 -- requirements
Module: gptp_2

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 16, meaning number of 80-bit words per TX frame.
REQ-002 SHALL have parameter TS_WORD, default 2, meaning the TX word index replaced by the RTC timestamp.
REQ-003 SHALL have parameter LINK_DELAY_NS, default 0, meaning the fixed path delay added to master time.
REQ-004 SHALL have parameter INC_NOMINAL, default 26'h80000, meaning the reset/nominal RTC increment (8.0 ns, 16 fractional bits).
REQ-005 SHALL have one clock and an asynchronous, active-high reset; ports: clk in 1 (clock); reset in 1 (async active-high reset).
REQ-006 SHALL have RTC update ports: gptp_vaild out 1 (update valid); rtc_ready in 1 (RTC accepts update); gptp_sw out 1 (synchronised flag).
REQ-007 SHALL have syntonised time outputs: syntonised_nanosec_field_r out 32; syntonised_sec_field_r out 32; syntonised_epoch_field_r out 16 (corrected time).
REQ-008 SHALL have offset outputs: nanosec_offset out 30; sec_offset out 32; epoch_offset out 16; rtc_increment out 26 (RTC step).
REQ-009 SHALL have RTC sample inputs: rtc_nanosec_field in 32; rtc_sec_field in 32; rtc_epoch_field in 16.
REQ-010 SHALL have RX buffer ports: rx_gptp_rd_vaild in 8 (frame type); rx_gptp_rd_data in 80; rx_gptp_rd_addr out 8; rx_gptp_rd_ready out 1 (read enable); gptp_wr_vaild_ready in 1 (TX buffer free).
REQ-011 SHALL have TX ports: gptp_rd_data in 80 (template); gptp_rd_addr out 8; gptp_wr_addr out 8; gptp_wr_data out 80; gptp_wr_vaild out 1 (write strobe); gptp_wr_ready in 1 (frame sent pulse).

Function
REQ-012 SHALL form timestamps as {epoch[15:0], sec[31:0], ns[31:0]}; ns always kept in 0..999_999_999.
REQ-013 SHALL implement FSM states IDLE, RX_RD, RX_CALC, TX_RD, TX_WAIT; RX has priority over TX in IDLE.
REQ-014 SHALL treat rx_gptp_rd_vaild[7]=1 (e.g. 8'hff) as no frame; otherwise [3:0] is messageType: 0x0 Sync, 0x8 Follow_Up, others ignored.
REQ-015 SHALL read all buffers with 1-cycle latency: data valid the cycle after address plus rx_gptp_rd_ready=1.
REQ-016 On Sync SHALL read addr 0 and latch it as ingress time t2; on Follow_Up SHALL read addr 0 as master time t1, then enter RX_CALC.
REQ-017 In RX_CALC SHALL compute offset = t1 + LINK_DELAY_NS - t2 with ns borrow/carry at 1e9 into sec, sec borrow into epoch (mod 2^16), and set syntonised_* = t1 + LINK_DELAY_NS.
REQ-018 SHALL ignore Follow_Up with no preceding Sync since reset or since the last calculation.
REQ-019 SHALL assert gptp_vaild one cycle after RX_CALC and hold it until a cycle with rtc_ready=1; a newer result while held overwrites the outputs.
REQ-020 SHALL set gptp_sw=1 on the first completed calculation and keep it until reset.
REQ-021 From IDLE with gptp_wr_vaild_ready=1 and no RX frame SHALL enter TX_RD, drive gptp_rd_addr=k for k=0..FRAME_WORDS-1 on consecutive cycles.
REQ-022 One cycle after each read SHALL drive gptp_wr_vaild=1, gptp_wr_addr=k, gptp_wr_data=gptp_rd_data, except word TS_WORD = current RTC sample.
REQ-023 gptp_wr_vaild_ready is sampled only in IDLE; its deassertion mid-frame SHALL NOT abort the copy.
REQ-024 After the last word SHALL wait in TX_WAIT for gptp_wr_ready=1, then return to IDLE; RX frames arriving meanwhile stay pending.
REQ-025 Addresses SHALL be 8-bit; FRAME_WORDS above 256 is unsupported.

Reset
REQ-026 Asserting reset at any time SHALL immediately force IDLE and set all outputs to 0, except rtc_increment=INC_NOMINAL; latched t1/t2 cleared.

Configuration
REQ-027 Macro GPTP_RATE_ADJ_EN: when defined, after each calculation SHALL compare the master interval (t1 delta) with the local interval (t2 delta) and step rtc_increment by -1 LSB if local>master, +1 if local<master, clamped to INC_NOMINAL +/- 2^12; when undefined, rtc_increment SHALL stay INC_NOMINAL.

Verification
REQ-028 Reset pulse -> all outputs 0, rtc_increment=26'h80000, gptp_sw=0.
REQ-029 gptp_wr_vaild_ready=1, rx 8'hff, gptp_rd_data=80'habababaa, RTC {0,1,5} -> 16 wr strobes addr 0..15, word 2 = {16'd0,32'd1,32'd5}, others 80'habababaa.
REQ-030 After frame, drop gptp_wr_vaild_ready, pulse gptp_wr_ready after 16 cycles -> FSM returns to IDLE, next frame starts when ready reasserted.
REQ-031 Sync t2={0,1,5}, Follow_Up t1={0,2,3} -> offset sec=0, ns=999_999_998, syntonised={0,2,3}, gptp_vaild held while rtc_ready=0, gptp_sw=1.
REQ-032 Follow_Up without Sync -> no gptp_vaild; reset during TX_RD -> gptp_wr_vaild=0 immediately.
